// File: rtl/panel_scan_controller.sv
// -----------------------------------------------------------------------------
// panel_scan_controller
//
// Sequences one LED panel: steps the row RAM address, sweeps the PWM
// comparison time 0..255 per row, emits the shift/latch strobes that feed
// the colour drivers, and slots brightness reloads in at frame boundaries.
//
// Ports:
//   clk              system clock
//   reset_n          synchronous active-low reset
//   enable           scan enable (honoured only in IDLE and at row ends)
//   brightness_req   level request for a brightness reload
//   brightness_ack   one-cycle pulse after the reload's last shift
//   shift            serial shift strobe (LED data or brightness data)
//   load_led_vals    one-cycle latch strobe for LED on/off values
//   load_brightness  one-cycle brightness parallel-load strobe
//   pwm_time         current PWM comparison time
//   active_row_addr  row RAM read address
//   row_select       physical row driven to the panel row decoder
//   blank            1 = all rows off
//   frame_done       one-cycle pulse after the last row wraps to row 0
// -----------------------------------------------------------------------------
module panel_scan_controller #(
    parameter int NUM_ROWS    = 16,
    parameter int SHIFT_BITS  = 16,
    parameter int HOLD_CYCLES = 4,
    parameter int BRIGHT_BITS = 96
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       brightness_req,
    output logic       brightness_ack,
    output logic       shift,
    output logic       load_led_vals,
    output logic       load_brightness,
    output logic [7:0] pwm_time,
    output logic [3:0] active_row_addr,
    output logic [3:0] row_select,
    output logic       blank,
    output logic       frame_done
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_LATCH  = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_BLOAD  = 3'd5;
    localparam logic [2:0] ST_BSHIFT = 3'd6;

    localparam logic [7:0] SHIFT_LAST  = 8'(SHIFT_BITS - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] BRIGHT_LAST = 8'(BRIGHT_BITS - 1);
    localparam logic [3:0] ROW_LAST    = 4'(NUM_ROWS - 1);
    localparam logic [7:0] PWM_LAST    = 8'd255;

    logic [2:0] state_r;
    logic [7:0] cnt_r;
    logic       pend_r;
    logic [7:0] pwm_r;
    logic [3:0] addr_r;
    logic [3:0] row_sel_r;
    logic       shift_r;
    logic       lled_r;
    logic       lbr_r;
    logic       blank_r;
    logic       fd_r;
    logic       ack_r;

    logic [2:0] state_s;
    logic [7:0] cnt_s;
    logic       pend_s;
    logic [7:0] pwm_s;
    logic [3:0] addr_s;
    logic       fd_s;
    logic       ack_s;
    logic       blank_s;
    logic       wrap_s;
    logic       bright_due_s;

    // Next-state, counter, PWM/row stepping and pending-request bookkeeping.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        pwm_s        = pwm_r;
        addr_s       = addr_r;
        fd_s         = 1'b0;
        ack_s        = 1'b0;
        pend_s       = pend_r | brightness_req;
        wrap_s       = (addr_r == ROW_LAST);
        bright_due_s = pend_r | brightness_req;
        case (state_r)
            ST_IDLE: begin
                if (bright_due_s) begin
                    state_s = ST_BLOAD;
                end else if (enable) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_s = ST_SHIFT;
                cnt_s   = 8'd0;
            end
            ST_SHIFT: begin
                if (cnt_r == SHIFT_LAST) begin
                    state_s = ST_LATCH;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_LATCH: begin
                state_s = ST_HOLD;
                cnt_s   = 8'd0;
            end
            ST_HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    cnt_s = 8'd0;
                    if (pwm_r != PWM_LAST) begin
                        pwm_s   = pwm_r + 8'd1;
                        state_s = ST_SHIFT;
                    end else begin
                        // Row boundary: the only place enable and a pending
                        // brightness reload are allowed to redirect the scan.
                        pwm_s  = 8'd0;
                        addr_s = wrap_s ? 4'd0 : (addr_r + 4'd1);
                        fd_s   = wrap_s;
                        if (!enable) begin
                            state_s = ST_IDLE;
                        end else if (wrap_s && bright_due_s) begin
                            state_s = ST_BLOAD;
                        end else begin
                            state_s = ST_FETCH;
                        end
                    end
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_BLOAD: begin
                state_s = ST_BSHIFT;
                cnt_s   = 8'd0;
            end
            ST_BSHIFT: begin
                if (cnt_r == BRIGHT_LAST) begin
                    // Requests seen during the reload are dropped here; a
                    // request still high in the ack cycle re-arms the flag.
                    pend_s  = 1'b0;
                    ack_s   = 1'b1;
                    cnt_s   = 8'd0;
                    state_s = enable ? ST_FETCH : ST_IDLE;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // Blanking for the coming cycle; FETCH and SHIFT keep the current image.
    always_comb begin
        blank_s = blank_r;
        case (state_s)
            ST_IDLE, ST_BLOAD, ST_BSHIFT: blank_s = 1'b1;
            ST_LATCH:                     blank_s = (pwm_s == 8'd0);
            ST_HOLD:                      blank_s = 1'b0;
            default:                      blank_s = blank_r;
        endcase
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            pend_r    <= 1'b0;
            pwm_r     <= 8'd0;
            addr_r    <= 4'd0;
            row_sel_r <= 4'd0;
            shift_r   <= 1'b0;
            lled_r    <= 1'b0;
            lbr_r     <= 1'b0;
            blank_r   <= 1'b1;
            fd_r      <= 1'b0;
            ack_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pend_r  <= pend_s;
            pwm_r   <= pwm_s;
            addr_r  <= addr_s;
            // The decoder moves to the new row only while the panel is
            // blanked by the first latch of that row.
            if ((state_r == ST_LATCH) && (pwm_r == 8'd0)) begin
                row_sel_r <= addr_r;
            end else begin
                row_sel_r <= row_sel_r;
            end
            shift_r <= (state_s == ST_SHIFT) || (state_s == ST_BSHIFT);
            lled_r  <= (state_s == ST_LATCH);
            lbr_r   <= (state_s == ST_BLOAD);
            blank_r <= blank_s;
            fd_r    <= fd_s;
            ack_r   <= ack_s;
        end
    end

    assign brightness_ack  = ack_r;
    assign shift           = shift_r;
    assign load_led_vals   = lled_r;
    assign load_brightness = lbr_r;
    assign pwm_time        = pwm_r;
    assign active_row_addr = addr_r;
    assign row_select      = row_sel_r;
    assign blank           = blank_r;
    assign frame_done      = fd_r;

endmodule

// File: tb/tb_panel_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_panel_scan_controller
//
// Lockstep bench: a reference model expands each scan decision (row, idle
// cycle, brightness reload) into a queue of expected per-cycle outputs built
// from the timing rules, and every cycle the DUT outputs are compared with
// the head of that queue. Smaller parameters keep whole frames short.
// -----------------------------------------------------------------------------
module tb_panel_scan_controller;

    localparam int NR      = 4;
    localparam int SB      = 8;
    localparam int HC      = 3;
    localparam int BB      = 12;
    localparam int ROW_CYC = 1 + 256 * (SB + 1 + HC);

    localparam int D_IDLE = 0;
    localparam int D_ROW  = 1;
    localparam int D_BRT  = 2;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       brightness_req;
    logic       brightness_ack;
    logic       shift;
    logic       load_led_vals;
    logic       load_brightness;
    logic [7:0] pwm_time;
    logic [3:0] active_row_addr;
    logic [3:0] row_select;
    logic       blank;
    logic       frame_done;

    panel_scan_controller #(
        .NUM_ROWS(NR), .SHIFT_BITS(SB), .HOLD_CYCLES(HC), .BRIGHT_BITS(BB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .brightness_req(brightness_req), .brightness_ack(brightness_ack),
        .shift(shift), .load_led_vals(load_led_vals),
        .load_brightness(load_brightness), .pwm_time(pwm_time),
        .active_row_addr(active_row_addr), .row_select(row_select),
        .blank(blank), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       shift;
        logic       lled;
        logic       lbr;
        logic       back;
        logic       fd;
        logic       blank;
        logic [7:0] pwm;
        logic [3:0] addr;
        logic [3:0] rsel;
        logic       clr;
    } rec_t;

    rec_t       q[$];
    rec_t       cur;
    logic [3:0] m_addr;
    logic [3:0] m_rsel;
    logic       m_pend;
    int         next_dec;

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic rec_t mk(input logic sh, input logic ll, input logic lb,
                                input logic bk, input logic fd, input logic bl,
                                input logic [7:0] pw);
        rec_t r;
        r.shift = sh; r.lled = ll; r.lbr = lb; r.back = bk; r.fd = fd;
        r.blank = bl; r.pwm = pw; r.addr = m_addr; r.rsel = m_rsel; r.clr = 1'b0;
        return r;
    endfunction

    // A whole row: FETCH, then 256 x (shift burst, latch, hold).
    task automatic push_row(input logic fd, input logic bk, input logic blank0);
        q.push_back(mk(1'b0, 1'b0, 1'b0, bk, fd, blank0, 8'd0));
        for (int t = 0; t < 256; t++) begin
            for (int s = 0; s < SB; s++)
                q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (t == 0) ? blank0 : 1'b0, 8'(t)));
            q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (t == 0), 8'(t)));
            if (t == 0) m_rsel = m_addr;
            for (int h = 0; h < HC; h++)
                q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'(t)));
        end
        next_dec = D_ROW;
    endtask

    task automatic push_idle(input logic fd, input logic bk);
        q.push_back(mk(1'b0, 1'b0, 1'b0, bk, fd, 1'b1, 8'd0));
        next_dec = D_IDLE;
    endtask

    task automatic push_bright(input logic fd);
        rec_t r;
        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, fd, 1'b1, 8'd0));
        for (int s = 0; s < BB; s++) begin
            r = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
            r.clr = (s == BB - 1);
            q.push_back(r);
        end
        next_dec = D_BRT;
    endtask

    task automatic decide();
        logic wrap;
        case (next_dec)
            D_IDLE: begin
                if (m_pend) push_bright(1'b0);
                else if (enable) push_row(1'b0, 1'b0, cur.blank);
                else push_idle(1'b0, 1'b0);
            end
            D_ROW: begin
                wrap = (m_addr == 4'(NR - 1));
                m_addr = wrap ? 4'd0 : m_addr + 4'd1;
                if (!enable) push_idle(wrap, 1'b0);
                else if (wrap && m_pend) push_bright(wrap);
                else push_row(wrap, 1'b0, cur.blank);
            end
            default: begin
                if (enable) push_row(1'b0, 1'b1, cur.blank);
                else push_idle(1'b0, 1'b1);
            end
        endcase
    endtask

    // One clock: advance the model on the edge, then compare a little later.
    task automatic tick();
        logic [31:0] obs;
        logic [31:0] exp;
        @(posedge clk);
        if (!reset_n) begin
            q.delete();
            m_addr = 4'd0;
            m_rsel = 4'd0;
            m_pend = 1'b0;
            push_idle(1'b0, 1'b0);
        end else begin
            if (cur.clr) m_pend = 1'b0;
            else if (brightness_req) m_pend = 1'b1;
            if (q.size() == 0) decide();
        end
        cur = q.pop_front();
        #1;
        obs = {10'd0, shift, load_led_vals, load_brightness, brightness_ack, frame_done,
               blank, pwm_time, active_row_addr, row_select};
        exp = {10'd0, cur.shift, cur.lled, cur.lbr, cur.back, cur.fd,
               cur.blank, cur.pwm, cur.addr, cur.rsel};
        check_eq("outputs", obs, exp);
        check_eq("strobe_excl", 32'(int'(shift) + int'(load_led_vals) + int'(load_brightness) > 1), 32'd0);
    endtask

    initial begin
        int  i;
        int  n;
        int  run;
        logic found;
        n_checks = 0;
        n_errors = 0;
        cur = '0;
        q.delete();
        m_addr = 4'd0; m_rsel = 4'd0; m_pend = 1'b0; next_dec = D_IDLE;
        reset_n = 1'b0; enable = 1'b0; brightness_req = 1'b0;
        tick();
        tick();
        check_eq("reset_blank", 32'(blank), 32'd1);
        reset_n = 1'b1;
        tick();
        enable = 1'b1;

        // First row: length and latch count.
        n = 0;
        for (i = 0; i < ROW_CYC + 100; i++) begin
            tick();
            if (load_led_vals) n++;
            if (cur.addr == 4'd1) break;
        end
        check_eq("row_cycles", 32'(i), 32'(ROW_CYC));
        check_eq("row_latches", 32'(n), 32'd256);

        // Brightness request mid-row of the last row: serviced only at wrap.
        found = 1'b0;
        for (i = 0; i < 4 * ROW_CYC; i++) begin
            tick();
            if (cur.addr == 4'(NR - 1)) begin found = 1'b1; break; end
        end
        check_eq("reach_last_row", 32'(found), 32'd1);
        for (i = 0; i < 1000; i++) tick();
        brightness_req = 1'b1;
        found = 1'b0;
        n = 0;
        for (i = 0; i < 2 * ROW_CYC; i++) begin
            tick();
            if (frame_done) n++;
            if (cur.back) begin found = 1'b1; brightness_req = 1'b0; break; end
        end
        brightness_req = 1'b0;
        check_eq("ack_timeout", 32'(found), 32'd1);
        check_eq("frame_done_count", 32'(n), 32'd1);

        // Randomised enable toggling and brightness requests.
        for (i = 0; i < 15000; i++) begin
            tick();
            if ($urandom_range(0, 999) < 2) enable = ~enable;
            if ($urandom_range(0, 1499) == 0) brightness_req = 1'b1;
            if (cur.back && ($urandom_range(0, 3) != 0)) brightness_req = 1'b0;
        end
        brightness_req = 1'b0;
        enable = 1'b1;

        // Drop enable mid-row: row completes, then quiet IDLE.
        for (i = 0; i < 600; i++) tick();
        enable = 1'b0;
        found = 1'b0;
        for (i = 0; i < 3 * ROW_CYC; i++) begin
            tick();
            if (next_dec == D_IDLE && !m_pend && q.size() == 0) begin found = 1'b1; break; end
        end
        check_eq("idle_timeout", 32'(found), 32'd1);
        n = 0;
        for (i = 0; i < 200; i++) begin
            tick();
            if (shift || load_led_vals || load_brightness) n++;
        end
        check_eq("idle_strobes", 32'(n), 32'd0);
        check_eq("idle_blank", 32'(blank), 32'd1);

        // Brightness request from IDLE.
        brightness_req = 1'b1;
        tick();
        brightness_req = 1'b0;
        found = 1'b0;
        for (i = 0; i < BB + 20; i++) begin
            tick();
            if (cur.back) begin found = 1'b1; break; end
        end
        check_eq("idle_ack_timeout", 32'(found), 32'd1);

        // Reset during the 7th shift cycle of a PWM step.
        enable = 1'b1;
        run = 0;
        found = 1'b0;
        for (i = 0; i < 2 * ROW_CYC; i++) begin
            tick();
            run = cur.shift ? run + 1 : 0;
            if (run == 7 && cur.pwm == 8'd3) begin found = 1'b1; break; end
        end
        check_eq("shift7_timeout", 32'(found), 32'd1);
        reset_n = 1'b0;
        tick();
        check_eq("mid_reset_state", {19'd0, shift, load_led_vals, load_brightness, blank, pwm_time, active_row_addr},
                 {19'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0});
        reset_n = 1'b1;
        for (i = 0; i < 400; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
